jtpinpon_objbuf: RTL and testbench

Double line buffer for the PinPon object path. Sits directly downstream of the object drawer: while the drawer writes the pixels of the next line into one bank, the other bank is read out in step with `hdump` and cleared behind the read. Banks swap at every line start (`hinit`). A reset-time sweep clears both banks. The output feeds the colour mixer.

---
 rtl/jtpinpon_objbuf.sv | 150 +++++++++++++++
 tb/tb_jtpinpon_objbuf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/jtpinpon_objbuf.sv
// Double line buffer for object pixels: the drawer fills one bank while the
// other is read out with hdump and cleared behind the read; banks swap on hinit.
module jtpinpon_objbuf #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          hinit,
    input  logic          LHBL,
    input  logic [8:0]    hdump,
    input  logic          wr_en,
    input  logic [8:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          ready,
    output logic          wr_bank,
    output logic [DW-1:0] pxl
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 9;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hinit_l_q, hinit_l_d;
    logic              wr_bank_q, wr_bank_d;
    logic              ready_q, ready_d;
    logic [DW-1:0]     pxl_q, pxl_d;
    logic              clr_pend_q, clr_pend_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic              clr_bank_q, clr_bank_d;

    logic [DW-1:0]     mem [2][DEPTH];

    logic [1:0]           we_c;
    logic [1:0][AW-1:0]   wa_c;
    logic [1:0][DW-1:0]   wd_c;
    logic [DW-1:0]        rd_data_c;
    logic                 swap_c;
    logic                 wr_fire_c;
    logic                 rd_fire_c;

    assign rd_data_c = mem[~wr_bank_q][AW'(hdump[7:0])];
    assign swap_c    = hinit & ~hinit_l_q;
    assign wr_fire_c = wr_en & ~wr_addr[8] & (wr_data != '0);
    assign rd_fire_c = pxl_cen & ~hdump[8];

    // Next state, per-bank RAM port selection and output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hinit_l_d  = hinit;
        wr_bank_d  = wr_bank_q;
        ready_d    = ready_q;
        pxl_d      = pxl_q;
        clr_pend_d = 1'b0;
        clr_addr_d = clr_addr_q;
        clr_bank_d = clr_bank_q;
        we_c       = '0;
        wa_c       = '0;
        wd_c       = '0;

        case (state_q)
            ST_INIT: begin
                pxl_d   = '0;
                ready_d = 1'b0;
                // cnt[8] picks the bank, cnt[7:0] the entry being zeroed
                we_c[cnt_q[8]] = 1'b1;
                wa_c[cnt_q[8]] = AW'(cnt_q[7:0]);
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(511)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_pend_q) begin
                    we_c[clr_bank_q] = 1'b1;
                    wa_c[clr_bank_q] = clr_addr_q;
                end
                // A drawer write right after a swap may hit the bank with a
                // pending clear; the drawer's pixel takes the port.
                if (wr_fire_c) begin
                    we_c[wr_bank_q] = 1'b1;
                    wa_c[wr_bank_q] = AW'(wr_addr[7:0]);
                    wd_c[wr_bank_q] = wr_data;
                end
                if (swap_c) begin
                    wr_bank_d = ~wr_bank_q;
                end
                if (pxl_cen) begin
                    pxl_d = (LHBL && !hdump[8]) ? rd_data_c : '0;
                end
                if (rd_fire_c) begin
                    clr_pend_d = 1'b1;
                    clr_addr_d = AW'(hdump[7:0]);
                    clr_bank_d = ~wr_bank_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            hinit_l_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            ready_q    <= 1'b0;
            pxl_q      <= '0;
            clr_pend_q <= 1'b0;
            clr_addr_q <= '0;
            clr_bank_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hinit_l_q  <= hinit_l_d;
            wr_bank_q  <= wr_bank_d;
            ready_q    <= ready_d;
            pxl_q      <= pxl_d;
            clr_pend_q <= clr_pend_d;
            clr_addr_q <= clr_addr_d;
            clr_bank_q <= clr_bank_d;
        end
    end

    // Bank storage, one write port each
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (we_c[b]) begin
                mem[b][wa_c[b]] <= wd_c[b];
            end
        end
    end

    assign ready   = ready_q;
    assign wr_bank = wr_bank_q;
    assign pxl     = pxl_q;

endmodule

// File: tb/tb_jtpinpon_objbuf.sv
// Directed bench for jtpinpon_objbuf: expected pixels are queued as reads are
// issued and compared when the registered output appears one clk later.
module tb_jtpinpon_objbuf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen;
    logic       hinit;
    logic       LHBL;
    logic [8:0] hdump;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [3:0] wr_data;
    logic       ready;
    logic       wr_bank;
    logic [3:0] pxl;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  line_exp [256];
    logic        exp_bank;

    always #5 clk = ~clk;

    jtpinpon_objbuf #(.AW(8), .DW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pxl_cen (pxl_cen),
        .hinit   (hinit),
        .LHBL    (LHBL),
        .hdump   (hdump),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready),
        .wr_bank (wr_bank),
        .pxl     (pxl)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue one pixel read (called at a negedge), check it one clk later
    task automatic pix(input logic [8:0] hd, input logic lb, input logic [3:0] e);
        pxl_cen = 1'b1;
        hdump   = hd;
        LHBL    = lb;
        exp_q.push_back(e);
        @(negedge clk);
        pxl_cen = 1'b0;
        chk("pxl", 9'(pxl), 9'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic read_line(input logic lb);
        for (int x = 0; x < 256; x++) pix(9'(x), lb, lb ? line_exp[x] : 4'h0);
        pix(9'h100, 1'b1, 4'h0);
        pix(9'h1FF, 1'b1, 4'h0);
        for (int x = 0; x < 256; x++) line_exp[x] = 4'h0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic swap(input logic with_wr, input logic [8:0] a, input logic [3:0] d);
        hinit = 1'b1;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = d;
        end
        @(negedge clk);
        wr_en    = 1'b0;
        exp_bank = ~exp_bank;
        chk("wr_bank", 9'(wr_bank), 9'(exp_bank));
        hinit = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_init();
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            chk("ready", 9'(ready), (i == 512) ? 9'd1 : 9'd0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pxl_cen = 1'b0;
        hinit   = 1'b0;
        LHBL    = 1'b1;
        hdump   = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        exp_bank = 1'b0;
        for (int x = 0; x < 256; x++) line_exp[x] = 4'h0;

        // Reset state and init sweep; inputs during INIT must be ignored
        @(negedge clk);
        @(negedge clk);
        chk("rst_pxl", 9'(pxl), 9'd0);
        chk("rst_ready", 9'(ready), 9'd0);
        chk("rst_wr_bank", 9'(wr_bank), 9'd0);
        rst_n = 1'b1;
        wait_init();
        chk("init_wr_bank", 9'(wr_bank), 9'd0);

        // First two lines read back empty
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);

        // Write, transparent skip, swap, read, cleared after two more swaps
        wr(9'd10, 4'h5);
        wr(9'd11, 4'h0);
        swap(1'b0, 9'h0, 4'h0);
        line_exp[10] = 4'h5;
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);

        // Last writer wins, off-line x discarded
        wr(9'd20, 4'h3);
        wr(9'd20, 4'h9);
        wr(9'h105, 4'h7);
        swap(1'b0, 9'h0, 4'h0);
        line_exp[20] = 4'h9;
        read_line(1'b1);

        // Blanked read still clears
        wr(9'd0, 4'h4);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b0);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);

        // Write in the swap cycle lands in the pre-swap bank
        swap(1'b1, 9'd30, 4'h6);
        line_exp[30] = 4'h6;
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);

        // Reset mid-line with data in both banks
        wr(9'd50, 4'h7);
        wr(9'd60, 4'h3);
        swap(1'b0, 9'h0, 4'h0);
        wr(9'd70, 4'h2);
        for (int x = 0; x <= 50; x++) pix(9'(x), 1'b1, (x == 50) ? 4'h7 : 4'h0);
        chk("pre_rst_pxl", 9'(pxl), 9'h7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pxl", 9'(pxl), 9'd0);
        chk("midrst_wr_bank", 9'(wr_bank), 9'd0);
        chk("midrst_ready", 9'(ready), 9'd0);
        exp_bank = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        for (int x = 0; x < 256; x++) line_exp[x] = 4'h0;
        read_line(1'b1);
        swap(1'b0, 9'h0, 4'h0);
        read_line(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
